// File: rtl/morse_pkg.sv
// Shared types and the A-Z Morse code table for the Morse letter sequencer.
// Each code is stored left-aligned: symbol 0 sits in the MSB, 1 = dash.
package morse_pkg;

    typedef enum logic [1:0] {
        IDLE,
        MARK,
        SPACE,
        TAIL
    } state_e;

    localparam int MAX_SYMBOLS = 4;
    localparam int DOT_UNITS   = 1;
    localparam int DASH_UNITS  = 3;

    typedef struct packed {
        logic                   invalid;
        logic [2:0]             len;
        logic [MAX_SYMBOLS-1:0] symbols;
    } code_t;

    function automatic code_t lookup_code(input logic [4:0] letter);
        logic [6:0] entry;
        code_t      c;
        case (letter)
            5'd0:    entry = {3'd2, 4'b0100};  // A .-
            5'd1:    entry = {3'd4, 4'b1000};  // B -...
            5'd2:    entry = {3'd4, 4'b1010};  // C -.-.
            5'd3:    entry = {3'd3, 4'b1000};  // D -..
            5'd4:    entry = {3'd1, 4'b0000};  // E .
            5'd5:    entry = {3'd4, 4'b0010};  // F ..-.
            5'd6:    entry = {3'd3, 4'b1100};  // G --.
            5'd7:    entry = {3'd4, 4'b0000};  // H ....
            5'd8:    entry = {3'd2, 4'b0000};  // I ..
            5'd9:    entry = {3'd4, 4'b0111};  // J .---
            5'd10:   entry = {3'd3, 4'b1010};  // K -.-
            5'd11:   entry = {3'd4, 4'b0100};  // L .-..
            5'd12:   entry = {3'd2, 4'b1100};  // M --
            5'd13:   entry = {3'd2, 4'b1000};  // N -.
            5'd14:   entry = {3'd3, 4'b1110};  // O ---
            5'd15:   entry = {3'd4, 4'b0110};  // P .--.
            5'd16:   entry = {3'd4, 4'b1101};  // Q --.-
            5'd17:   entry = {3'd3, 4'b0100};  // R .-.
            5'd18:   entry = {3'd3, 4'b0000};  // S ...
            5'd19:   entry = {3'd1, 4'b1000};  // T -
            5'd20:   entry = {3'd3, 4'b0010};  // U ..-
            5'd21:   entry = {3'd4, 4'b0001};  // V ...-
            5'd22:   entry = {3'd3, 4'b0110};  // W .--
            5'd23:   entry = {3'd4, 4'b1001};  // X -..-
            5'd24:   entry = {3'd4, 4'b1011};  // Y -.--
            5'd25:   entry = {3'd4, 4'b1100};  // Z --..
            default: entry = '0;
        endcase
        c.invalid = (letter > 5'd25);
        c.len     = entry[6:4];
        c.symbols = entry[3:0];
        return c;
    endfunction

endpackage

// File: rtl/morse_unit_timer.sv
// Free-running unit timer: UnitTick is high for one cycle every TICKS cycles.
// Restart zeroes the count so the next tick lands exactly TICKS cycles later.
module morse_unit_timer #(
    parameter int TICKS = 4
) (
    input  logic ClockIn,
    input  logic Reset,
    input  logic Restart,
    output logic UnitTick
);

    localparam int            CW   = $clog2(TICKS) + 1;
    localparam logic [CW-1:0] LAST = CW'(TICKS - 1);

    logic [CW-1:0] r_count;

    assign UnitTick = (r_count == LAST);

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge ClockIn or negedge Reset) begin
        if (!Reset) begin
            r_count <= '0;
        end else if (Restart || UnitTick) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + 1'b1;
        end
    end

endmodule

// File: rtl/morse_sequencer.sv
// Morse letter transmitter: latches a letter's code on Start and plays its
// dots, dashes and gaps on DotDashOut, timed in whole units from morse_unit_timer.
module morse_sequencer
    import morse_pkg::*;
#(
    parameter int CLOCK_FREQUENCY  = 500,
    parameter int UNIT_MS          = 500,
    parameter int LETTER_GAP_UNITS = 3
) (
    input  logic       ClockIn,
    input  logic       Reset,
    input  logic       Start,
    input  logic [4:0] Letter,
    output logic       DotDashOut,
    output logic       NewBitOut,
    output logic       Busy,
    output logic       Done,
    output logic       Error
);

    localparam int TICKS = CLOCK_FREQUENCY * UNIT_MS / 1000;

    generate
        if (TICKS < 1) begin : g_bad_ticks
            $error("morse_sequencer: CLOCK_FREQUENCY*UNIT_MS/1000 must be at least 1");
        end
        if (LETTER_GAP_UNITS < 1 || LETTER_GAP_UNITS > 7) begin : g_bad_gap
            $error("morse_sequencer: LETTER_GAP_UNITS must be in 1..7");
        end
    endgenerate

    localparam logic [2:0] DOT_LAST  = 3'(DOT_UNITS - 1);
    localparam logic [2:0] DASH_LAST = 3'(DASH_UNITS - 1);
    localparam logic [2:0] GAP_LAST  = 3'(LETTER_GAP_UNITS - 1);

    state_e                 r_state;
    state_e                 w_next;
    logic [2:0]             r_len;
    logic [MAX_SYMBOLS-1:0] r_syms;
    logic [1:0]             r_idx;
    logic [2:0]             r_units;
    code_t                  w_code;
    logic                   w_unit_tick;
    logic                   w_restart;
    logic                   w_accept;
    logic                   w_reject;
    logic                   w_more;
    logic [2:0]             w_mark_last;

    assign w_code    = lookup_code(Letter);
    assign w_restart = (w_next != r_state);

    morse_unit_timer #(
        .TICKS(TICKS)
    ) u_timer (
        .ClockIn (ClockIn),
        .Reset   (Reset),
        .Restart (w_restart),
        .UnitTick(w_unit_tick)
    );

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        w_next      = r_state;
        w_accept    = 1'b0;
        w_reject    = 1'b0;
        w_more      = (({1'b0, r_idx}) + 3'd1) < r_len;
        w_mark_last = r_syms[2'd3 - r_idx] ? DASH_LAST : DOT_LAST;
        case (r_state)
            IDLE: begin
                if (Start) begin
                    if (w_code.invalid) begin
                        w_reject = 1'b1;
                    end else begin
                        w_accept = 1'b1;
                        w_next   = MARK;
                    end
                end
            end
            MARK: begin
                if (w_unit_tick && (r_units == w_mark_last)) begin
                    w_next = w_more ? SPACE : TAIL;
                end
            end
            SPACE: begin
                if (w_unit_tick) begin
                    w_next = MARK;
                end
            end
            TAIL: begin
                if (w_unit_tick && (r_units == GAP_LAST)) begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they change on the same edge as the FSM.
    always_ff @(posedge ClockIn or negedge Reset) begin
        if (!Reset) begin
            r_state    <= IDLE;
            r_len      <= '0;
            r_syms     <= '0;
            r_idx      <= '0;
            r_units    <= '0;
            DotDashOut <= 1'b0;
            NewBitOut  <= 1'b0;
            Busy       <= 1'b0;
            Done       <= 1'b0;
            Error      <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_restart || (r_state == IDLE)) begin
                r_units <= '0;
            end else if (w_unit_tick) begin
                r_units <= r_units + 3'd1;
            end
            if (w_accept) begin
                r_len  <= w_code.len;
                r_syms <= w_code.symbols;
                r_idx  <= '0;
            end else if ((r_state == SPACE) && (w_next == MARK)) begin
                r_idx <= r_idx + 2'd1;
            end
            DotDashOut <= (w_next == MARK);
            NewBitOut  <= (w_next == MARK) && (r_state != MARK);
            Busy       <= (w_next != IDLE);
            Done       <= (r_state == TAIL) && (w_next == IDLE);
            Error      <= w_reject;
        end
    end

endmodule

// File: tb/tb_morse_sequencer.sv
// Scoreboard bench for morse_sequencer: expected waveforms come from plain
// Morse strings; a negedge monitor rebuilds each transmission and compares.
module tb_morse_sequencer;

    localparam int TICKS = 4;
    localparam int GAP   = 3;

    typedef struct {
        bit    is_err;
        string sig;
    } exp_t;

    logic       clk     = 1'b0;
    logic       rst_n   = 1'b0;
    logic       start   = 1'b0;
    logic [4:0] letter  = '0;
    logic       start2  = 1'b0;
    logic [4:0] letter2 = '0;
    logic       dot, newbit, busy, done, err;
    logic       dot2, newbit2, busy2, done2, err2;

    int   n_cmp  = 0;
    int   n_fail = 0;
    exp_t exp_q[$];

    string morse [26] = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..",
                          ".---", "-.-", ".-..", "--", "-.", "---", ".--.", "--.-", ".-.",
                          "...", "-", "..-", "...-", ".--", "-..-", "-.--", "--.."};

    always #5 clk = ~clk;

    morse_sequencer #(
        .CLOCK_FREQUENCY (8),
        .UNIT_MS         (500),
        .LETTER_GAP_UNITS(GAP)
    ) u_dut (
        .ClockIn   (clk),
        .Reset     (rst_n),
        .Start     (start),
        .Letter    (letter),
        .DotDashOut(dot),
        .NewBitOut (newbit),
        .Busy      (busy),
        .Done      (done),
        .Error     (err)
    );

    morse_sequencer #(
        .CLOCK_FREQUENCY (2),
        .UNIT_MS         (500),
        .LETTER_GAP_UNITS(1)
    ) u_dut_fast (
        .ClockIn   (clk),
        .Reset     (rst_n),
        .Start     (start2),
        .Letter    (letter2),
        .DotDashOut(dot2),
        .NewBitOut (newbit2),
        .Busy      (busy2),
        .Done      (done2),
        .Error     (err2)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_str(input string name, input string act, input string exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got \"%s\", expected \"%s\"", name, act, exp);
        end
    endtask

    // Run lengths of DotDashOut while busy (marks, spaces, tail), then NewBitOut counts.
    function automatic string expected_sig(input string code);
        string s;
        s = "";
        for (int i = 0; i < code.len(); i++) begin
            s = {s, $sformatf("%0d,", (code[i] == "-") ? 3 * TICKS : TICKS)};
            if (i < code.len() - 1) s = {s, $sformatf("%0d,", TICKS)};
        end
        return {s, $sformatf("%0d,nb%0d/%0d", GAP * TICKS, code.len(), code.len())};
    endfunction

    task automatic expect_letter(input logic [4:0] l);
        exp_t e;
        e.is_err = (l > 5'd25);
        e.sig    = e.is_err ? "" : expected_sig(morse[l]);
        exp_q.push_back(e);
    endtask

    // Called at a negedge; Start is sampled on the following posedge.
    task automatic send(input logic [4:0] l, input bit push);
        start  = 1'b1;
        letter = l;
        if (push) expect_letter(l);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int cyc;
        cyc = 0;
        while ((exp_q.size() != 0 || busy) && cyc < 300) begin
            @(negedge clk);
            cyc++;
        end
        @(negedge clk);
        check({name, "_drained"}, exp_q.size(), 0);
    endtask

    // Monitor: rebuilds each transmission and pops the scoreboard on Done or Error.
    bit    in_tx = 1'b0;
    logic  run_val;
    bit    new_run;
    int    run_len, nb_cnt, nb_ok;
    string run_str, obs;
    exp_t  mon_e;

    always @(negedge clk) begin
        if (!rst_n) begin
            in_tx   = 1'b0;
            run_str = "";
        end else begin
            if (busy) begin
                if (!in_tx) begin
                    in_tx   = 1'b1;
                    run_str = "";
                    run_val = dot;
                    run_len = 1;
                    nb_cnt  = 0;
                    nb_ok   = 0;
                    new_run = 1'b1;
                end else if (dot == run_val) begin
                    run_len++;
                    new_run = 1'b0;
                end else begin
                    run_str = {run_str, $sformatf("%0d,", run_len)};
                    run_val = dot;
                    run_len = 1;
                    new_run = 1'b1;
                end
                if (newbit) nb_cnt++;
                if (newbit && dot && new_run) nb_ok++;
            end
            if (done) begin
                obs   = in_tx ? {run_str, $sformatf("%0d,nb%0d/%0d", run_len, nb_cnt, nb_ok)} : "no-busy";
                in_tx = 1'b0;
                check("done_with_busy_low", busy, 0);
                if (exp_q.size() == 0) begin
                    check_str("spurious_done", obs, "<nothing pending>");
                end else begin
                    mon_e = exp_q.pop_front();
                    check_str("letter_waveform", obs, mon_e.is_err ? "<error pulse>" : mon_e.sig);
                end
            end
            if (err) begin
                if (exp_q.size() == 0) begin
                    check_str("spurious_error", "error", "<nothing pending>");
                end else begin
                    mon_e = exp_q.pop_front();
                    check("error_expected", mon_e.is_err, 1);
                end
                check("error_quiet_outputs", {busy, dot, done}, 0);
            end
        end
    end

    task automatic run_fast(input logic [4:0] l, input string name);
        int marks, busy_cnt, nb, cyc, exp_mark;
        string c;
        c        = morse[l];
        exp_mark = 0;
        for (int i = 0; i < c.len(); i++) exp_mark += (c[i] == "-") ? 3 : 1;
        start2  = 1'b1;
        letter2 = l;
        @(negedge clk);
        start2   = 1'b0;
        marks    = 0;
        busy_cnt = 0;
        nb       = 0;
        cyc      = 0;
        while (!done2 && cyc < 60) begin
            busy_cnt += int'(busy2);
            marks    += int'(dot2);
            nb       += int'(newbit2);
            @(negedge clk);
            cyc++;
        end
        check({name, "_done"}, done2, 1);
        check({name, "_mark_cycles"}, marks, exp_mark);
        check({name, "_busy_cycles"}, busy_cnt, exp_mark + c.len() - 1 + 1);
        check({name, "_newbits"}, nb, c.len());
        check({name, "_no_error"}, err2, 0);
        @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cyc;
        repeat (3) @(negedge clk);
        check("reset_outputs", {dot, newbit, busy, done, err}, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_outputs", {dot, newbit, busy, done, err}, 0);

        // Single letters, an invalid code, and a Start pulse while busy that must be ignored.
        send(5'd4, 1'b1);
        wait_drain("letter_e");
        send(5'd16, 1'b1);
        wait_drain("letter_q");
        send(5'd27, 1'b1);
        wait_drain("invalid_27");
        send(5'd0, 1'b1);
        repeat (3) @(negedge clk);
        send(5'd25, 1'b0);
        wait_drain("start_while_busy");

        // Start held high: back-to-back A's, with Letter disturbed mid-letter.
        start  = 1'b1;
        letter = 5'd0;
        expect_letter(5'd0);
        for (int k = 0; k < 3; k++) begin
            repeat (6) @(negedge clk);
            letter = 5'd25;
            cyc    = 0;
            while (!done && cyc < 100) begin
                @(negedge clk);
                cyc++;
            end
            check("b2b_done_seen", done, 1);
            letter = 5'd0;
            if (k < 2) begin
                expect_letter(5'd0);
                @(negedge clk);
                check("b2b_restart_same_cycle", {busy, dot, newbit}, 3'b111);
            end else begin
                start = 1'b0;
                @(negedge clk);
                check("b2b_stop", busy, 0);
            end
        end
        wait_drain("back_to_back");

        // Asynchronous reset in the middle of Q's first dash.
        send(5'd16, 1'b0);
        repeat (5) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_outputs", {dot, newbit, busy, done, err}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send(5'd4, 1'b1);
        wait_drain("after_reset_e");

        for (int i = 0; i < 40; i++) begin
            send(5'($urandom_range(0, 31)), 1'b1);
            wait_drain("random");
        end

        run_fast(5'd19, "fast_t");
        run_fast(5'd16, "fast_q");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/morse_sequencer.md
# morse_sequencer

Parametrised Morse letter transmitter covering the full A–Z alphabet with variable-length codes. It has a Start/Busy/Done handshake and configurable unit timing. It is the successor to the fixed eight-letter encoder: it sits between letter-selection logic (switches or an upstream text FSM) and the LED driver. It times dots, dashes, inter-symbol gaps and an inter-letter gap from a single unit tick.

## Interface
- CLOCK_FREQUENCY, 500, ClockIn frequency in Hz.
- UNIT_MS, 500, dot duration in ms; TICKS = CLOCK_FREQUENCY*UNIT_MS/1000. Elaboration fails if TICKS < 1.
- LETTER_GAP_UNITS, 3, units of space after the last symbol before Done (legal range 1..7).
- ClockIn  input  1  sole clock, rising edge.
- Reset  input  1  asynchronous, active-low reset.
- Start  input  1  request transmission of Letter; sampled only when Busy=0.
- Letter  input  5  0=A … 25=Z; 26..31 invalid.
- DotDashOut  output  1  registered mark output (1 = LED on).
- NewBitOut  output  1  one-cycle pulse coincident with the first cycle of every mark.
- Busy  output  1  high from acceptance until the letter gap completes.
- Done  output  1  one-cycle pulse on the first cycle Busy is low after a transmission.
- Error  output  1  one-cycle pulse when Start is sampled with an invalid Letter.

## Operation
- Code table: per letter, a 3-bit length n (1..4) and 4 symbol bits, MSB first (1 = dash). Examples: E = n1 "0"; Q = n4 "1101"; A = n2 "01".
- Durations: dot = 1 unit; dash = 3 units; gap between symbols = 1 unit; trailing gap = LETTER_GAP_UNITS units.
- FSM states:
  - IDLE: Start with a valid Letter latches the code and the symbol index goes to MARK. Start with an invalid Letter pulses Error next cycle and stays in IDLE.
  - MARK: DotDashOut=1 for 1 or 3 units. Then go to SPACE if symbols remain, otherwise TAIL.
  - SPACE: DotDashOut=0 for 1 unit, then MARK with the next symbol.
  - TAIL: DotDashOut=0 for LETTER_GAP_UNITS units, then IDLE with Done pulse.
- Start while Busy=1 is ignored; Letter changes while busy have no effect (the code is latched).
- The unit timer restarts at every state entry, so no partial units are carried over.
- Reset (Reset=0) at any time forces IDLE immediately and clears the latched code and counters. All outputs go to 0: DotDashOut, NewBitOut, Busy, Done, Error.

## Timing
- Start sampled at edge k in IDLE: Busy, DotDashOut and NewBitOut are all 1 from edge k. NewBitOut drops at k+1.
- Each mark holds DotDashOut=1 for exactly 1*TICKS or 3*TICKS cycles. Each space holds exactly TICKS cycles.
- Total Busy cycles = TICKS * (sum of mark units + (n-1) + LETTER_GAP_UNITS).
- Done=1 and Busy=0 in the same cycle. A Start sampled in that cycle is accepted, giving back-to-back letters with no extra idle cycle.
- Error is asserted one cycle after the invalid Start is sampled. Busy stays 0 and no marks are emitted.
- Counter widths: the tick counter is $clog2(TICKS)+1 bits; the unit counter is 3 bits. No wrap is reachable within legal parameters.

## Structure
- morse_pkg holds:
  - the state enum (IDLE, MARK, SPACE, TAIL);
  - MAX_SYMBOLS=4, DOT_UNITS=1, DASH_UNITS=3;
  - a constant function or localparam array mapping 0..25 to {length, symbols}, plus an invalid flag.
- Sub-module morse_unit_timer: takes ClockIn, Reset and Restart, and produces a one-cycle UnitTick every TICKS cycles. It is parametrised by TICKS.
- Top: the FSM, the symbol index, the unit counter and the output registers.

## Test plan
- CLOCK_FREQUENCY=8, UNIT_MS=500 (TICKS=4), Letter=4 (E) → DotDashOut high 4 cycles, low 12 cycles. Busy high 16 cycles. Done pulse at cycle 16. One NewBitOut pulse.
- Letter=16 (Q) → marks of 12,12,4,12 cycles with 4-cycle gaps. Four NewBitOut pulses. Busy high 4*(10+3+3)=64 cycles.
- Start held high continuously with Letter=0 (A) → repeated transmissions with Done and the next mark beginning in the same cycle. Letter toggled to 25 mid-letter does not alter the current letter.
- Start with Letter=27 → Error pulse one cycle later. Busy, DotDashOut and Done stay 0.
- Reset asserted mid-dash of a Q transmission → all outputs 0 asynchronously. After release, Start with Letter=4 produces a clean 4-cycle dot.
- LETTER_GAP_UNITS=1, TICKS=1, Letter=19 (T) → DotDashOut high 3 cycles. Busy 4 cycles total.
